if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch front end for the 5-stage pipeline. Owns the program counter and issues requests to instruction memory. Buffers fetched words in a 2-entry queue and presents them, pre-split into opcode and function fields, to the inputs of the IF/ID pipeline register. Honours stall from the hazard unit and branch/jump redirects, which flush queued and in-flight fetches.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- BUBBLE, 32'hFC00_0000, instruction word presented when no valid instruction (opcode 6'b111111 = pipeline NOP)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold the current output; no pop this cycle
- redirect  in  1  branch/jump taken; flush and refetch
- redirect_pc  in  32  target PC, sampled when redirect=1
- imem_req  out  1  fetch request; held until imem_ready
- imem_addr  out  32  fetch address; stable while imem_req=1
- imem_ready  in  1  imem_rdata valid this cycle; request completes
- imem_rdata  in  32  fetched instruction word
- valid_out  out  1  queue head is a real instruction
- ctr  out  6  instru[31:26] of head, else 6'b111111
- funcode  out  6  instru[5:0] of head, else 6'b000000
- instru  out  32  head instruction, else BUBBLE
- nextpc  out  32  fetch address of head + 4, else 0

## Operation
- State: pc[31:0] (next address to request), 2-entry FIFO of {instr, pc+4}, count[1:0], FSM.
- FSM states:
  - IDLE: imem_req=0.
  - REQ: imem_req=1, imem_addr=pc.
  - DISCARD: imem_req=1, imem_addr=pc_old. Result will be dropped.
- A request completes when imem_req && imem_ready.
- Pop = valid_out && !stall && !redirect.
- Push = a completion in REQ with no redirect. The FIFO gets {imem_rdata, pc+4} and pc <= pc+4.
- count_next = count - pop + push. Range 0..2.
  - The one in-flight request always has a reserved slot, so push never overflows.
  - A push into an empty FIFO cannot become the head in the same cycle.
- REQ:
  - completion: stay in REQ if count_next<2, else go to IDLE.
  - no completion: stay in REQ.
- IDLE → REQ when count_next<2.
- Redirect (priority over stall and push):
  - FIFO flushed: count <= 0.
  - REQ, no completion: go to DISCARD; the pending address is held until ready; pc <= redirect_pc.
  - REQ, with completion: the word is dropped; pc <= redirect_pc; stay in REQ.
  - IDLE: pc <= redirect_pc; go to REQ.
  - DISCARD: pc <= redirect_pc (latest redirect wins); stay in DISCARD.
- DISCARD: on completion the word is dropped and the FSM goes to REQ (count is 0).
- Output fields come combinationally from the FIFO head register only, never from imem_rdata.
- Reset (async, rst_n=0):
  - pc=RESET_PC, count=0, state=IDLE.
  - Outputs: imem_req=0, valid_out=0, ctr=6'b111111, funcode=0, instru=BUBBLE, nextpc=0.
  - Reset mid-request abandons it; memory must tolerate request drop.

## Timing
- Cycle 0: first rising edge after rst_n deasserts moves IDLE→REQ. imem_req=1 with imem_addr=RESET_PC during cycle 1.
- Zero-wait memory (ready in the request cycle): instruction is on the outputs the cycle after completion.
- Steady state: 1 instruction/cycle.
- Stall: the head is held while stalled.
  - Fetch continues until count=2 with no request outstanding; the FSM then sits in IDLE.
  - After stall drops, the outputs change at the next clock edge (head popped).
- Redirect at edge N: valid_out=0 during cycle N+1.
  - Earliest target word on outputs: cycle N+2 with zero-wait memory.
  - Later if a DISCARD is needed.
- imem_addr must never change while imem_req=1 and imem_ready=0.

## Test plan
- Reset, zero-wait memory returning addr-derived words, no stall:
  - imem_addr sequence 0,4,8,…
  - Output instr at 0 appears with nextpc=4; one per cycle.
  - valid_out=0 and instru=32'hFC000000 before the first fetch.
- Stall held 5 cycles while streaming:
  - Outputs frozen on one word.
  - imem_req drops once count=2.
  - Release: next two words come out back-to-back, then the stream continues with no loss or duplication.
- Memory with 3-cycle wait:
  - imem_addr stable across wait cycles.
  - Throughput 1 per 3–4 cycles.
  - nextpc correct.
- Redirect to 32'h0000_0100 while a request to 0x10 is waiting 2 more cycles:
  - 0x10 word dropped.
  - Next request addr=0x100.
  - First valid output instru=mem[0x100], nextpc=0x104.
- Redirect with simultaneous stall and a full FIFO: FIFO flushed, stall ignored for the flush, valid_out=0 next cycle.
- Assert rst_n=0 mid-request: imem_req and valid_out drop immediately (asynchronously). After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner, imem requester and 2-entry fetch queue feeding the IF/ID register
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] BUBBLE   = 32'hFC00_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        valid_out,
    output logic [5:0]  ctr,
    output logic [5:0]  funcode,
    output logic [31:0] instru,
    output logic [31:0] nextpc
);
    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t      state_q;
    logic [31:0] pc_q, addr_q;
    logic        req_q;
    logic [1:0]  count_q, count_d;
    logic [31:0] instr_q [2];
    logic [31:0] npc_q [2];
    logic        pop, done, push, wr_idx;

    assign valid_out = count_q != 2'd0;
    assign pop       = valid_out && !stall && !redirect;
    assign done      = req_q && imem_ready;
    assign push      = done && state_q == REQ && !redirect;
    assign count_d   = redirect ? 2'd0 : count_q - {1'b0, pop} + {1'b0, push};
    // first free slot once this cycle's pop has shifted the queue
    assign wr_idx    = pop ? count_q[1] : count_q[0];

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign instru    = valid_out ? instr_q[0] : BUBBLE;
    assign nextpc    = valid_out ? npc_q[0] : 32'h0;
    assign ctr       = instru[31:26];
    assign funcode   = instru[5:0];

    // Queue storage: shift toward the head on pop, append fetched word on push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q[0] <= 32'h0;
            instr_q[1] <= 32'h0;
            npc_q[0]   <= 32'h0;
            npc_q[1]   <= 32'h0;
        end else begin
            if (pop) begin
                instr_q[0] <= instr_q[1];
                npc_q[0]   <= npc_q[1];
            end
            if (push) begin
                instr_q[wr_idx] <= imem_rdata;
                npc_q[wr_idx]   <= pc_q + 32'd4;
            end
        end
    end

    // Fetch FSM with registered request/address; redirect overrides stall and push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            count_q <= 2'd0;
        end else begin
            count_q <= count_d;
            if (redirect)
                pc_q <= redirect_pc;
            else if (push)
                pc_q <= pc_q + 32'd4;
            case (state_q)
                IDLE: begin
                    if (redirect || count_d != 2'd2) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        addr_q  <= redirect ? redirect_pc : pc_q;
                    end
                end
                REQ: begin
                    if (redirect) begin
                        if (done)
                            addr_q <= redirect_pc;
                        else
                            state_q <= DISCARD;
                    end else if (done) begin
                        addr_q <= pc_q + 32'd4;
                        if (count_d == 2'd2) begin
                            state_q <= IDLE;
                            req_q   <= 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    if (done) begin
                        state_q <= REQ;
                        addr_q  <= redirect ? redirect_pc : pc_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed checks of the fetch unit against a wait-state memory model
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req, imem_ready, valid_out;
    logic [31:0] imem_addr, imem_rdata, instru, nextpc;
    logic [5:0]  ctr, funcode;
    logic [1:0]  wait_cfg = 2'd0;
    logic [1:0]  wcnt = 2'd0;
    int          checks = 0;
    int          errors = 0;

    localparam logic [31:0] BUBBLE = 32'hFC00_0000;

    if_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .valid_out(valid_out),
        .ctr(ctr), .funcode(funcode), .instru(instru), .nextpc(nextpc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1234_0000;
    endfunction

    assign imem_ready = imem_req && (wcnt == wait_cfg);
    assign imem_rdata = mem_word(imem_addr);

    always @(posedge clk)
        wcnt <= (!imem_req || imem_ready) ? 2'd0 : wcnt + 2'd1;

    task automatic do_reset(input logic [1:0] w);
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; wait_cfg = w;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; wait_cfg = 2'd0;
        @(negedge clk);
        checks++;
        if ({imem_req, valid_out, ctr, funcode, instru, nextpc} !== {1'b0, 1'b0, 6'h3f, 6'h00, BUBBLE, 32'h0}) begin
            $display("FAIL reset_outputs: got %h expected %h", {imem_req, valid_out, ctr, funcode, instru, nextpc},
                     {1'b0, 1'b0, 6'h3f, 6'h00, BUBBLE, 32'h0});
            errors++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({imem_req, imem_addr, valid_out, instru} !== {1'b1, 32'h0, 1'b0, BUBBLE}) begin
            $display("FAIL first_request: got %h expected %h", {imem_req, imem_addr, valid_out, instru},
                     {1'b1, 32'h0, 1'b0, BUBBLE});
            errors++;
        end
    endtask

    task automatic test_stream();
        do_reset(2'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if ({valid_out, instru, nextpc, imem_req, imem_addr} !==
                {1'b1, mem_word(32'(4 * k)), 32'(4 * k + 4), 1'b1, 32'(4 * k + 4)}) begin
                $display("FAIL stream_%0d: got %h expected %h", k, {valid_out, instru, nextpc, imem_req, imem_addr},
                         {1'b1, mem_word(32'(4 * k)), 32'(4 * k + 4), 1'b1, 32'(4 * k + 4)});
                errors++;
            end
        end
        checks++;
        if ({ctr, funcode} !== {6'h04, 6'h14}) begin
            $display("FAIL stream_fields: got %h expected %h", {ctr, funcode}, {6'h04, 6'h14});
            errors++;
        end
    endtask

    task automatic test_stall();
        do_reset(2'd0);
        @(negedge clk);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({valid_out, instru, imem_req} !== {1'b1, mem_word(32'h0), 1'b0}) begin
                $display("FAIL stall_hold_%0d: got %h expected %h", i, {valid_out, instru, imem_req},
                         {1'b1, mem_word(32'h0), 1'b0});
                errors++;
            end
        end
        stall = 1'b0;
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({valid_out, instru, nextpc} !== {1'b1, mem_word(32'(4 * k)), 32'(4 * k + 4)}) begin
                $display("FAIL stall_release_%0d: got %h expected %h", k, {valid_out, instru, nextpc},
                         {1'b1, mem_word(32'(4 * k)), 32'(4 * k + 4)});
                errors++;
            end
        end
    endtask

    task automatic test_wait_states();
        int          n = 0;
        int          last = 0;
        logic        p_wait = 1'b0;
        logic [31:0] p_addr = 32'h0;
        do_reset(2'd3);
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            @(negedge clk);
            if (p_wait) begin
                checks++;
                if (imem_addr !== p_addr) begin
                    $display("FAIL wait_addr_stable: got %h expected %h", imem_addr, p_addr);
                    errors++;
                end
            end
            p_wait = imem_req && !imem_ready;
            p_addr = imem_addr;
            if (valid_out) begin
                checks++;
                if ({instru, nextpc} !== {mem_word(32'(4 * n)), 32'(4 * n + 4)}) begin
                    $display("FAIL wait_word_%0d: got %h expected %h", n, {instru, nextpc},
                             {mem_word(32'(4 * n)), 32'(4 * n + 4)});
                    errors++;
                end
                if (n > 0) begin
                    checks++;
                    if (cyc - last != 4) begin
                        $display("FAIL wait_spacing_%0d: got %0d expected 4", n, cyc - last);
                        errors++;
                    end
                end
                last = cyc;
                n++;
            end
        end
        checks++;
        if (n != 4) begin
            $display("FAIL wait_timeout: got %0d words expected 4", n);
            errors++;
        end
    endtask

    task automatic test_redirect_discard();
        bit found = 0;
        bit got_addr = 0;
        bit got_word = 0;
        do_reset(2'd3);
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            found = imem_req && imem_addr == 32'h10 && wcnt == 2'd1;
        end
        checks++;
        if (!found) begin
            $display("FAIL redir_setup: got no wait on 0x10 expected one");
            errors++;
        end
        redirect = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        redirect = 1'b0;
        checks++;
        if ({valid_out, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h10}) begin
            $display("FAIL redir_discard_hold: got %h expected %h", {valid_out, imem_req, imem_addr}, {1'b0, 1'b1, 32'h10});
            errors++;
        end
        for (int i = 0; i < 20 && !got_word; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr != 32'h10 && !got_addr) begin
                got_addr = 1;
                checks++;
                if (imem_addr !== 32'h100) begin
                    $display("FAIL redir_next_addr: got %h expected %h", imem_addr, 32'h100);
                    errors++;
                end
            end
            if (valid_out) begin
                got_word = 1;
                checks++;
                if ({instru, nextpc} !== {mem_word(32'h100), 32'h104}) begin
                    $display("FAIL redir_first_word: got %h expected %h", {instru, nextpc}, {mem_word(32'h100), 32'h104});
                    errors++;
                end
            end
        end
        checks++;
        if (!got_word) begin
            $display("FAIL redir_timeout: got no valid word expected mem[0x100]");
            errors++;
        end
    endtask

    task automatic test_redirect_full();
        do_reset(2'd0);
        @(negedge clk);
        stall = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({valid_out, imem_req, instru} !== {1'b1, 1'b0, mem_word(32'h0)}) begin
            $display("FAIL full_idle: got %h expected %h", {valid_out, imem_req, instru}, {1'b1, 1'b0, mem_word(32'h0)});
            errors++;
        end
        redirect = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        checks++;
        if ({valid_out, instru, nextpc, imem_req, imem_addr} !== {1'b0, BUBBLE, 32'h0, 1'b1, 32'h200}) begin
            $display("FAIL full_flush: got %h expected %h", {valid_out, instru, nextpc, imem_req, imem_addr},
                     {1'b0, BUBBLE, 32'h0, 1'b1, 32'h200});
            errors++;
        end
        redirect = 1'b0; stall = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if ({valid_out, instru, nextpc} !== {1'b1, mem_word(32'(32'h200 + 4 * k)), 32'(32'h204 + 4 * k)}) begin
                $display("FAIL full_target_%0d: got %h expected %h", k, {valid_out, instru, nextpc},
                         {1'b1, mem_word(32'(32'h200 + 4 * k)), 32'(32'h204 + 4 * k)});
                errors++;
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset(2'd3);
        repeat (4) @(negedge clk);
        checks++;
        if ({valid_out, imem_req, imem_addr, instru} !== {1'b1, 1'b1, 32'h4, mem_word(32'h0)}) begin
            $display("FAIL areset_pre: got %h expected %h", {valid_out, imem_req, imem_addr, instru},
                     {1'b1, 1'b1, 32'h4, mem_word(32'h0)});
            errors++;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_req, valid_out, instru} !== {1'b0, 1'b0, BUBBLE}) begin
            $display("FAIL areset_drop: got %h expected %h", {imem_req, valid_out, instru}, {1'b0, 1'b0, BUBBLE});
            errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({imem_req, imem_addr, valid_out} !== {1'b1, 32'h0, 1'b0}) begin
            $display("FAIL areset_restart: got %h expected %h", {imem_req, imem_addr, valid_out}, {1'b1, 32'h0, 1'b0});
            errors++;
        end
        repeat (4) @(negedge clk);
        checks++;
        if ({valid_out, instru, nextpc} !== {1'b1, mem_word(32'h0), 32'h4}) begin
            $display("FAIL areset_first_word: got %h expected %h", {valid_out, instru, nextpc}, {1'b1, mem_word(32'h0), 32'h4});
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_wait_states();
        test_redirect_discard();
        test_redirect_full();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
